key_conditioner: RTL and testbench

Front-end conditioner for the board pushbuttons. It synchronises and debounces the raw active-low KEY inputs, then produces one-cycle press and release pulses. For selected keys it also produces auto-repeat step pulses. It sits directly upstream of the lab top-level UI logic, which consumes the step and press pulses for offset browse, offset reset and run start.

---
 rtl/key_conditioner.sv | 141 ++++++++++++++
 tb/tb_key_conditioner.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// Pushbutton front end: 2-FF synchroniser, per-key debounce, press/release pulses
// and optional auto-repeat step pulses. All outputs are registered, keys independent.
module key_conditioner #(
    parameter int unsigned      NKEYS         = 4,
    parameter int unsigned      DB_CYCLES     = 50000,
    parameter int unsigned      DELAY_CYCLES  = 12500000,
    parameter int unsigned      REPEAT_CYCLES = 5000000,
    parameter logic [NKEYS-1:0] REPEAT_MASK   = NKEYS'(4'b0011)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [NKEYS-1:0] key_n_i,
    input  logic             repeat_en_i,
    input  logic             repeat_clr_i,
    output logic [NKEYS-1:0] level_o,
    output logic [NKEYS-1:0] press_o,
    output logic [NKEYS-1:0] release_o,
    output logic [NKEYS-1:0] step_o,
    output logic [NKEYS-1:0] repeating_o
);

    localparam int unsigned DbW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned CntMax = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES
                                                                     : REPEAT_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [DbW-1:0]  DbLast     = DbW'(DB_CYCLES - 1);
    localparam logic [CntW-1:0] DelayLast  = CntW'(DELAY_CYCLES - 1);
    localparam logic [CntW-1:0] RepeatLast = CntW'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StSuppress} state_e;

    logic [NKEYS-1:0] sync1_q, sync2_q;
    logic [NKEYS-1:0] level_q, level_d;
    logic [NKEYS-1:0] press_q, press_d;
    logic [NKEYS-1:0] release_q, release_d;
    logic [NKEYS-1:0] step_q, step_d;
    logic [NKEYS-1:0] rep_q, rep_d;
    logic [DbW-1:0]   db_cnt_q [NKEYS];
    logic [DbW-1:0]   db_cnt_d [NKEYS];
    logic [CntW-1:0]  ar_cnt_q [NKEYS];
    logic [CntW-1:0]  ar_cnt_d [NKEYS];
    state_e           state_q  [NKEYS];
    state_e           state_d  [NKEYS];

    always_comb begin
        for (int i = 0; i < NKEYS; i++) begin
            db_cnt_d[i]  = '0;
            level_d[i]   = level_q[i];
            step_d[i]    = 1'b0;
            rep_d[i]     = rep_q[i];
            state_d[i]   = state_q[i];
            ar_cnt_d[i]  = ar_cnt_q[i];

            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DbLast) begin
                    level_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end

            press_d[i]   = level_d[i] & ~level_q[i];
            release_d[i] = ~level_d[i] & level_q[i];

            if (release_d[i]) begin
                state_d[i]  = StIdle;
                ar_cnt_d[i] = '0;
                rep_d[i]    = 1'b0;
            end else if (press_d[i]) begin
                // Non-repeating presses park in StSuppress until release.
                step_d[i]   = 1'b1;
                ar_cnt_d[i] = '0;
                state_d[i]  = (REPEAT_MASK[i] && repeat_en_i && !repeat_clr_i) ? StDelay
                                                                               : StSuppress;
            end else begin
                unique case (state_q[i])
                    StDelay, StRepeat: begin
                        if (!repeat_en_i || repeat_clr_i) begin
                            state_d[i]  = StSuppress;
                            ar_cnt_d[i] = '0;
                            rep_d[i]    = 1'b0;
                        end else if (state_q[i] == StDelay) begin
                            if (ar_cnt_q[i] == DelayLast) begin
                                step_d[i]   = 1'b1;
                                rep_d[i]    = 1'b1;
                                state_d[i]  = StRepeat;
                                ar_cnt_d[i] = '0;
                            end else begin
                                ar_cnt_d[i] = ar_cnt_q[i] + 1'b1;
                            end
                        end else if (ar_cnt_q[i] == RepeatLast) begin
                            step_d[i]   = 1'b1;
                            ar_cnt_d[i] = '0;
                        end else begin
                            ar_cnt_d[i] = ar_cnt_q[i] + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            step_q    <= '0;
            rep_q     <= '0;
            for (int i = 0; i < NKEYS; i++) begin
                db_cnt_q[i] <= '0;
                ar_cnt_q[i] <= '0;
                state_q[i]  <= StIdle;
            end
        end else begin
            sync1_q   <= ~key_n_i;
            sync2_q   <= sync1_q;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            step_q    <= step_d;
            rep_q     <= rep_d;
            for (int i = 0; i < NKEYS; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                ar_cnt_q[i] <= ar_cnt_d[i];
                state_q[i]  <= state_d[i];
            end
        end
    end

    assign level_o     = level_q;
    assign press_o     = press_q;
    assign release_o   = release_q;
    assign step_o      = step_q;
    assign repeating_o = rep_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with short debounce/repeat timings.
module tb_key_conditioner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key_n;
    logic       repeat_en;
    logic       repeat_clr;
    logic [3:0] level_w, press_w, rel_w, step_w, rep_w;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    key_conditioner #(
        .NKEYS        (4),
        .DB_CYCLES    (4),
        .DELAY_CYCLES (10),
        .REPEAT_CYCLES(3),
        .REPEAT_MASK  (4'b0011)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .key_n_i     (key_n),
        .repeat_en_i (repeat_en),
        .repeat_clr_i(repeat_clr),
        .level_o     (level_w),
        .press_o     (press_w),
        .release_o   (rel_w),
        .step_o      (step_w),
        .repeating_o (rep_w)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // {level, press, release, step, repeating} for one key
    function automatic logic [4:0] obs(input int k);
        return {level_w[k], press_w[k], rel_w[k], step_w[k], rep_w[k]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        key_n      = 4'hF;
        repeat_en  = 1'b1;
        repeat_clr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [4:0] exp;

        // 1: hold key 0, full repeat cycle, release
        do_reset();
        check("reset outputs", {level_w, press_w, rel_w, step_w, rep_w}, 20'h0);
        key_n[0] = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            // level stays high until edge 35, so repeat ticks continue at 31 and 34
            exp = {e >= 6 && e < 36, e == 6, e == 36,
                   e inside {6, 16, 19, 22, 25, 28, 31, 34}, e >= 16 && e < 36};
            check($sformatf("s1 k0 e%0d", e), obs(0), exp);
            if (e == 30) key_n[0] = 1'b1;
        end
        check("s1 other keys", {level_w[3:1], press_w[3:1], step_w[3:1]}, 9'h0);

        // 2: bouncing key 2, then held
        do_reset();
        key_n[2] = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            exp = {e >= 18, e == 18, 1'b0, e == 18, 1'b0};
            check($sformatf("s2 k2 e%0d", e), obs(2), exp);
            if (e < 12 && e % 2 == 0) key_n[2] = ~key_n[2];
            if (e == 12) key_n[2] = 1'b0;
        end

        // 3: key 3 has no repeat
        do_reset();
        key_n[3] = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            exp = {e >= 6, e == 6, 1'b0, e == 6, 1'b0};
            check($sformatf("s3 k3 e%0d", e), obs(3), exp);
        end

        // 4: repeat_clr sampled at edge 20, release, re-press
        do_reset();
        key_n[0] = 1'b0;
        for (int e = 1; e <= 55; e++) begin
            tick();
            exp = {(e >= 6 && e < 31) || e >= 40, e == 6 || e == 40, e == 31,
                   e inside {6, 16, 19, 40, 50, 53}, (e >= 16 && e < 20) || e >= 50};
            check($sformatf("s4 k0 e%0d", e), obs(0), exp);
            repeat_clr = (e == 19);
            if (e == 25) key_n[0] = 1'b1;
            if (e == 34) key_n[0] = 1'b0;
        end

        // 5: asynchronous reset while key 1 is held
        do_reset();
        key_n[1] = 1'b0;
        for (int e = 1; e <= 11; e++) begin
            tick();
            exp = {e >= 6, e == 6, 1'b0, e == 6, 1'b0};
            check($sformatf("s5 pre k1 e%0d", e), obs(1), exp);
        end
        #2 rst_n = 1'b0;
        #1 check("s5 async reset", {level_w, press_w, rel_w, step_w, rep_w}, 20'h0);
        repeat (2) @(posedge clk);
        #1 check("s5 held reset", {level_w, press_w, rel_w, step_w, rep_w}, 20'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {e >= 6, e == 6, 1'b0, e == 6, 1'b0};
            check($sformatf("s5 post k1 e%0d", e), obs(1), exp);
        end

        // 6: keys 0 and 1 together with repeat disabled
        do_reset();
        repeat_en = 1'b0;
        key_n[1:0] = 2'b00;
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp = {e >= 6, e == 6, 1'b0, e == 6, 1'b0};
            check($sformatf("s6 k0 e%0d", e), obs(0), exp);
            check($sformatf("s6 k1 e%0d", e), obs(1), exp);
        end

        // 7: repeat_en dropped during delay, restored: no resume until re-press
        do_reset();
        key_n[0] = 1'b0;
        for (int e = 1; e <= 25; e++) begin
            tick();
            exp = {e >= 6, e == 6, 1'b0, e == 6, 1'b0};
            check($sformatf("s7 k0 e%0d", e), obs(0), exp);
            if (e == 9) repeat_en = 1'b0;
            if (e == 11) repeat_en = 1'b1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
